alu_reservation_station: RTL and testbench

Reservation station in front of the ALU functional unit. Accepts dispatched ALU micro-ops whose operands may still be pending, snoops the functional-unit completion broadcast to capture operand values and flags by ROB tag, and issues the oldest fully-ready entry to the ALU as a registered, one-cycle start pulse. It is the issuing end of the RS→ALU start/ready interface and the consuming end of the FU→ROB completion bus.

---
 rtl/alu_reservation_station_if.sv | 72 +++++++
 rtl/alu_reservation_station.sv | 187 ++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_reservation_station_if.sv
// Shared ALU op/flag types plus the dispatch, completion-broadcast and ALU-issue bundle of the station.
// No logic here, so there is no latency.
// out_dispatch_ready and in_alu_ready carry the backpressure in each direction.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4
`endif

package alu_rs_pkg;
  typedef enum logic [3:0] {
    ALU_OP_PLUS, ALU_OP_MINUS, ALU_OP_AND, ALU_OP_ORR, ALU_OP_EOR,
    ALU_OP_LSL, ALU_OP_LSR, ALU_OP_CSEL, ALU_OP_CSINC, ALU_OP_CSINV, ALU_OP_CSNEG
  } alu_op_t;
  typedef logic [3:0] nzcv_t;
endpackage

interface alu_reservation_station_if;
  import alu_rs_pkg::*;

  logic                     in_flush;
  logic                     in_dispatch_valid;
  alu_op_t                  in_dispatch_op;
  logic                     in_dispatch_a_ready;
  logic                     in_dispatch_b_ready;
  logic [`GPR_SIZE-1:0]     in_dispatch_val_a;
  logic [`GPR_SIZE-1:0]     in_dispatch_val_b;
  logic [`ROB_IDX_SIZE-1:0] in_dispatch_a_tag;
  logic [`ROB_IDX_SIZE-1:0] in_dispatch_b_tag;
  logic                     in_dispatch_nzcv_ready;
  nzcv_t                    in_dispatch_nzcv;
  logic [`ROB_IDX_SIZE-1:0] in_dispatch_nzcv_tag;
  logic                     in_dispatch_set_nzcv;
  logic [`ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index;
  logic                     out_dispatch_ready;
  logic                     in_fu_done;
  logic [`ROB_IDX_SIZE-1:0] in_fu_dst_rob_index;
  logic [`GPR_SIZE-1:0]     in_fu_value;
  logic                     in_fu_set_nzcv;
  nzcv_t                    in_fu_nzcv;
  logic                     in_alu_ready;
  logic                     out_alu_start;
  alu_op_t                  out_alu_op;
  logic [`GPR_SIZE-1:0]     out_alu_val_a;
  logic [`GPR_SIZE-1:0]     out_alu_val_b;
  logic [`ROB_IDX_SIZE-1:0] out_alu_dst_rob_index;
  logic                     out_alu_set_nzcv;
  nzcv_t                    out_alu_nzcv;

  // Environment side: dispatcher, completion bus and ALU.
  modport master (
    output in_flush, in_dispatch_valid, in_dispatch_op, in_dispatch_a_ready, in_dispatch_b_ready,
           in_dispatch_val_a, in_dispatch_val_b, in_dispatch_a_tag, in_dispatch_b_tag,
           in_dispatch_nzcv_ready, in_dispatch_nzcv, in_dispatch_nzcv_tag, in_dispatch_set_nzcv,
           in_dispatch_dst_rob_index, in_fu_done, in_fu_dst_rob_index, in_fu_value,
           in_fu_set_nzcv, in_fu_nzcv, in_alu_ready,
    input  out_dispatch_ready, out_alu_start, out_alu_op, out_alu_val_a, out_alu_val_b,
           out_alu_dst_rob_index, out_alu_set_nzcv, out_alu_nzcv
  );

  // Station side.
  modport slave (
    input  in_flush, in_dispatch_valid, in_dispatch_op, in_dispatch_a_ready, in_dispatch_b_ready,
           in_dispatch_val_a, in_dispatch_val_b, in_dispatch_a_tag, in_dispatch_b_tag,
           in_dispatch_nzcv_ready, in_dispatch_nzcv, in_dispatch_nzcv_tag, in_dispatch_set_nzcv,
           in_dispatch_dst_rob_index, in_fu_done, in_fu_dst_rob_index, in_fu_value,
           in_fu_set_nzcv, in_fu_nzcv, in_alu_ready,
    output out_dispatch_ready, out_alu_start, out_alu_op, out_alu_val_a, out_alu_val_b,
           out_alu_dst_rob_index, out_alu_set_nzcv, out_alu_nzcv
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched micro-ops, wakes them from the completion bus, and issues the oldest ready one.
// Latency is 2 edges from a ready dispatch or from the last wakeup to out_alu_start.
// Dispatch stalls while every slot is full, and issue waits while in_alu_ready is low.
module alu_reservation_station
  import alu_rs_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input logic                       in_clk,
  input logic                       in_rst_n,
  alu_reservation_station_if.slave  rs_if
);
  localparam int GW   = `GPR_SIZE;
  localparam int RW   = `ROB_IDX_SIZE;
  localparam int IDXW = $clog2(ENTRIES);

  typedef struct packed {
    alu_op_t         op;
    logic            a_rdy;
    logic [GW-1:0]   a_val;
    logic [RW-1:0]   a_tag;
    logic            b_rdy;
    logic [GW-1:0]   b_val;
    logic [RW-1:0]   b_tag;
    logic            f_rdy;
    nzcv_t           f_val;
    logic [RW-1:0]   f_tag;
    logic            set_nzcv;
    logic [RW-1:0]   dst;
  } rs_entry_t;

  typedef struct packed {
    alu_op_t       op;
    logic [GW-1:0] val_a;
    logic [GW-1:0] val_b;
    logic [RW-1:0] dst;
    logic          set_nzcv;
    nzcv_t         nzcv;
  } iss_t;

  logic [ENTRIES-1:0]              valid_q, valid_d;
  logic [ENTRIES-1:0][ENTRIES-1:0] older_q, older_d;  // [i][j] set: entry i is older than entry j
  rs_entry_t                       entry_q [ENTRIES];
  rs_entry_t                       entry_d [ENTRIES];
  logic                            start_q, start_d;
  iss_t                            iss_q, iss_d;

  logic [ENTRIES-1:0] rdy_vec, win_vec;
  logic               any_rdy, disp_rdy;
  logic [IDXW-1:0]    sel_idx, free_idx;
  rs_entry_t          new_entry;

  function automatic logic is_cond(input alu_op_t op);
    return (op == ALU_OP_CSEL) || (op == ALU_OP_CSINC) ||
           (op == ALU_OP_CSINV) || (op == ALU_OP_CSNEG);
  endfunction

  // Capture a completing result into whichever fields of an entry are waiting on its tag.
  function automatic rs_entry_t wake(input rs_entry_t e, input logic done, input logic [RW-1:0] tag,
                                     input logic [GW-1:0] val, input logic setf, input nzcv_t fl);
    rs_entry_t w;
    w = e;
    if (done && !e.a_rdy && (e.a_tag == tag)) begin
      w.a_rdy = 1'b1;
      w.a_val = val;
    end
    if (done && !e.b_rdy && (e.b_tag == tag)) begin
      w.b_rdy = 1'b1;
      w.b_val = val;
    end
    if (done && setf && !e.f_rdy && (e.f_tag == tag)) begin
      w.f_rdy = 1'b1;
      w.f_val = fl;
    end
    return w;
  endfunction

  assign disp_rdy                    = ~&valid_q;
  assign rs_if.out_dispatch_ready    = disp_rdy;
  assign rs_if.out_alu_start         = start_q;
  assign rs_if.out_alu_op            = iss_q.op;
  assign rs_if.out_alu_val_a         = iss_q.val_a;
  assign rs_if.out_alu_val_b         = iss_q.val_b;
  assign rs_if.out_alu_dst_rob_index = iss_q.dst;
  assign rs_if.out_alu_set_nzcv      = iss_q.set_nzcv;
  assign rs_if.out_alu_nzcv          = iss_q.nzcv;

  // Oldest-ready select and lowest free slot, both from registered state only.
  always_comb begin
    rdy_vec  = '0;
    win_vec  = '0;
    sel_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      rdy_vec[i] = valid_q[i] & entry_q[i].a_rdy & entry_q[i].b_rdy & entry_q[i].f_rdy;
    end
    for (int i = 0; i < ENTRIES; i++) begin
      win_vec[i] = rdy_vec[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if ((j != i) && rdy_vec[j] && older_q[j][i]) win_vec[i] = 1'b0;
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (win_vec[i]) sel_idx = IDXW'(i);
      if (!valid_q[i]) free_idx = IDXW'(i);
    end
    any_rdy = |rdy_vec;
  end

  // Incoming micro-op; flags are forced ready (and zero) for ops that do not read them.
  always_comb begin
    new_entry.op       = rs_if.in_dispatch_op;
    new_entry.a_rdy    = rs_if.in_dispatch_a_ready;
    new_entry.a_val    = rs_if.in_dispatch_val_a;
    new_entry.a_tag    = rs_if.in_dispatch_a_tag;
    new_entry.b_rdy    = rs_if.in_dispatch_b_ready;
    new_entry.b_val    = rs_if.in_dispatch_val_b;
    new_entry.b_tag    = rs_if.in_dispatch_b_tag;
    new_entry.f_rdy    = rs_if.in_dispatch_nzcv_ready;
    new_entry.f_val    = rs_if.in_dispatch_nzcv;
    new_entry.f_tag    = rs_if.in_dispatch_nzcv_tag;
    new_entry.set_nzcv = rs_if.in_dispatch_set_nzcv;
    new_entry.dst      = rs_if.in_dispatch_dst_rob_index;
    if (!is_cond(rs_if.in_dispatch_op)) begin
      new_entry.f_rdy = 1'b1;
      new_entry.f_val = '0;
    end
    new_entry = wake(new_entry, rs_if.in_fu_done, rs_if.in_fu_dst_rob_index,
                     rs_if.in_fu_value, rs_if.in_fu_set_nzcv, rs_if.in_fu_nzcv);
  end

  // Next state: wakeup, issue, dispatch, then flush overriding all of them.
  always_comb begin
    valid_d = valid_q;
    older_d = older_q;
    start_d = 1'b0;
    iss_d   = iss_q;
    for (int i = 0; i < ENTRIES; i++) begin
      entry_d[i] = wake(entry_q[i], rs_if.in_fu_done, rs_if.in_fu_dst_rob_index,
                        rs_if.in_fu_value, rs_if.in_fu_set_nzcv, rs_if.in_fu_nzcv);
    end
    if (rs_if.in_alu_ready && any_rdy) begin
      start_d           = 1'b1;
      iss_d.op          = entry_q[sel_idx].op;
      iss_d.val_a       = entry_q[sel_idx].a_val;
      iss_d.val_b       = entry_q[sel_idx].b_val;
      iss_d.dst         = entry_q[sel_idx].dst;
      iss_d.set_nzcv    = entry_q[sel_idx].set_nzcv;
      iss_d.nzcv        = entry_q[sel_idx].f_val;
      valid_d[sel_idx]  = 1'b0;
    end
    // free_idx comes from valid_q, so a slot freed by this issue cannot be refilled until next cycle.
    if (rs_if.in_dispatch_valid && disp_rdy) begin
      valid_d[free_idx] = 1'b1;
      entry_d[free_idx] = new_entry;
      for (int j = 0; j < ENTRIES; j++) begin
        older_d[free_idx][j] = 1'b0;
        older_d[j][free_idx] = valid_q[j];
      end
    end
    if (rs_if.in_flush) begin
      valid_d = '0;
      older_d = '0;
      start_d = 1'b0;
    end
  end

  // Control and issue registers with synchronous reset.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      valid_q <= '0;
      older_q <= '0;
      start_q <= 1'b0;
      iss_q   <= '0;
    end else begin
      valid_q <= valid_d;
      older_q <= older_d;
      start_q <= start_d;
      iss_q   <= iss_d;
    end
  end

  // Entry payload needs no reset; its valid bit qualifies it.
  always_ff @(posedge in_clk) begin
    for (int i = 0; i < ENTRIES; i++) entry_q[i] <= entry_d[i];
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed dispatch/wakeup/flush vectors with a scoreboard of expected issues.
// Expected issues are queued by the stimulus and consumed by a monitor on every out_alu_start.
// Includes stall (in_alu_ready low) and full-station drop scenarios.
module tb_alu_reservation_station;
  import alu_rs_pkg::*;

  typedef struct packed {
    alu_op_t                  op;
    logic [`GPR_SIZE-1:0]     a;
    logic [`GPR_SIZE-1:0]     b;
    logic [`ROB_IDX_SIZE-1:0] dst;
    logic                     setf;
    nzcv_t                    nzcv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   iss_cyc[$];
  exp_t act, e;

  always #5 clk = ~clk;

  alu_reservation_station_if rs_if ();

  alu_reservation_station #(.ENTRIES(4)) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .rs_if    (rs_if)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Monitor: sample just after each rising edge and score every issue pulse.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rs_if.out_alu_start === 1'b1) begin
      act.op   = rs_if.out_alu_op;
      act.a    = rs_if.out_alu_val_a;
      act.b    = rs_if.out_alu_val_b;
      act.dst  = rs_if.out_alu_dst_rob_index;
      act.setf = rs_if.out_alu_set_nzcv;
      act.nzcv = rs_if.out_alu_nzcv;
      iss_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got op=%0d a=%0h dst=%0d, required no issue",
                 act.op, act.a, act.dst);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL issue: got op=%0d a=%0h b=%0h dst=%0d setf=%0b nzcv=%b, required op=%0d a=%0h b=%0h dst=%0d setf=%0b nzcv=%b",
                   act.op, act.a, act.b, act.dst, act.setf, act.nzcv,
                   e.op, e.a, e.b, e.dst, e.setf, e.nzcv);
        end
      end
    end
  end

  task automatic set_disp(input alu_op_t op, input logic ar, input logic [63:0] va, input logic [3:0] at,
                          input logic br, input logic [63:0] vb, input logic [3:0] bt,
                          input logic fr, input nzcv_t fv, input logic [3:0] ft,
                          input logic setf, input logic [3:0] dst);
    rs_if.in_dispatch_valid         = 1'b1;
    rs_if.in_dispatch_op            = op;
    rs_if.in_dispatch_a_ready       = ar;
    rs_if.in_dispatch_val_a         = va;
    rs_if.in_dispatch_a_tag         = at;
    rs_if.in_dispatch_b_ready       = br;
    rs_if.in_dispatch_val_b         = vb;
    rs_if.in_dispatch_b_tag         = bt;
    rs_if.in_dispatch_nzcv_ready    = fr;
    rs_if.in_dispatch_nzcv          = fv;
    rs_if.in_dispatch_nzcv_tag      = ft;
    rs_if.in_dispatch_set_nzcv      = setf;
    rs_if.in_dispatch_dst_rob_index = dst;
  endtask

  task automatic set_fu(input logic [3:0] tag, input logic [63:0] val, input logic setf, input nzcv_t fl);
    rs_if.in_fu_done          = 1'b1;
    rs_if.in_fu_dst_rob_index = tag;
    rs_if.in_fu_value         = val;
    rs_if.in_fu_set_nzcv      = setf;
    rs_if.in_fu_nzcv          = fl;
  endtask

  task automatic step();
    @(negedge clk);
    rs_if.in_dispatch_valid = 1'b0;
    rs_if.in_fu_done        = 1'b0;
    rs_if.in_flush          = 1'b0;
  endtask

  task automatic push(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] dst, input logic setf, input nzcv_t fl);
    exp_t x;
    x.op = op; x.a = a; x.b = b; x.dst = dst; x.setf = setf; x.nzcv = fl;
    exp_q.push_back(x);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) step();
    step();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  int base;

  initial begin
    rst_n = 1'b0;
    rs_if.in_flush = 1'b0;
    rs_if.in_alu_ready = 1'b1;
    set_disp(ALU_OP_PLUS, 1'b0, 64'd0, 4'd0, 1'b0, 64'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
    rs_if.in_dispatch_valid = 1'b0;
    set_fu(4'd0, 64'd0, 1'b0, 4'd0);
    rs_if.in_fu_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_start", 64'(rs_if.out_alu_start), 64'd0);
    chk("reset_dispatch_ready", 64'(rs_if.out_dispatch_ready), 64'd1);
    chk("reset_val_a", rs_if.out_alu_val_a, 64'd0);
    rst_n = 1'b1;
    step();

    // Ready dispatch; a flag-writing non-conditional op issues nzcv as 0.
    set_disp(ALU_OP_PLUS, 1'b1, 64'd5, 4'd0, 1'b1, 64'd7, 4'd0, 1'b0, 4'b1111, 4'd9, 1'b1, 4'd2);
    push(ALU_OP_PLUS, 64'd5, 64'd7, 4'd2, 1'b1, 4'b0000);
    step();
    step();
    chk("ready_dispatch_latency", 64'(rs_if.out_alu_start), 64'd1);
    wait_drain("ready_dispatch_drain");

    // Wakeup of operand A from the completion bus.
    set_disp(ALU_OP_MINUS, 1'b0, 64'd0, 4'd3, 1'b1, 64'd1, 4'd0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd5);
    step();
    step();
    step();
    chk("wakeup_no_early_issue", 64'(iss_cyc.size()), 64'd1);
    set_fu(4'd3, 64'd42, 1'b0, 4'd0);
    push(ALU_OP_MINUS, 64'd42, 64'd1, 4'd5, 1'b0, 4'd0);
    step();
    step();
    chk("wakeup_latency", 64'(rs_if.out_alu_start), 64'd1);
    wait_drain("wakeup_drain");

    // Same-cycle bypass of the broadcast into the dispatching entry.
    set_disp(ALU_OP_MINUS, 1'b0, 64'd0, 4'd3, 1'b1, 64'd1, 4'd0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd7);
    set_fu(4'd3, 64'd42, 1'b0, 4'd0);
    push(ALU_OP_MINUS, 64'd42, 64'd1, 4'd7, 1'b0, 4'd0);
    step();
    step();
    chk("bypass_latency", 64'(rs_if.out_alu_start), 64'd1);
    wait_drain("bypass_drain");

    // Fill all four slots, drop a fifth, then release them in dispatch order.
    for (int i = 0; i < 4; i++) begin
      set_disp(ALU_OP_PLUS, 1'b0, 64'd0, 4'd6, 1'b1, 64'(i + 1), 4'd0, 1'b1, 4'd0, 4'd0, 1'b0, 4'(8 + i));
      step();
    end
    chk("full_dispatch_ready", 64'(rs_if.out_dispatch_ready), 64'd0);
    set_disp(ALU_OP_AND, 1'b1, 64'd99, 4'd0, 1'b1, 64'd99, 4'd0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd12);
    step();
    step();
    step();
    chk("full_drop_still_full", 64'(rs_if.out_dispatch_ready), 64'd0);
    base = iss_cyc.size();
    for (int i = 0; i < 4; i++) push(ALU_OP_PLUS, 64'd100, 64'(i + 1), 4'(8 + i), 1'b0, 4'd0);
    set_fu(4'd6, 64'd100, 1'b0, 4'd0);
    step();
    wait_drain("full_drain");
    chk("full_issue_count", 64'(iss_cyc.size() - base), 64'd4);
    if (iss_cyc.size() >= base + 4)
      chk("full_back_to_back", 64'(iss_cyc[base + 3] - iss_cyc[base]), 64'd3);
    chk("full_empty_after", 64'(rs_if.out_dispatch_ready), 64'd1);

    // Conditional op waits for a flag-carrying broadcast.
    set_disp(ALU_OP_CSEL, 1'b1, 64'd3, 4'd0, 1'b1, 64'd9, 4'd0, 1'b0, 4'd0, 4'd4, 1'b0, 4'd1);
    step();
    base = iss_cyc.size();
    set_fu(4'd4, 64'd55, 1'b0, 4'b1111);
    step();
    repeat (3) step();
    chk("flags_no_issue_without_nzcv", 64'(iss_cyc.size() - base), 64'd0);
    push(ALU_OP_CSEL, 64'd3, 64'd9, 4'd1, 1'b0, 4'b0100);
    set_fu(4'd4, 64'd77, 1'b1, 4'b0100);
    step();
    wait_drain("flags_drain");

    // Stall with two ready entries, then flush in the same cycle the ALU becomes ready.
    rs_if.in_alu_ready = 1'b0;
    set_disp(ALU_OP_ORR, 1'b1, 64'd1, 4'd0, 1'b1, 64'd2, 4'd0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd13);
    step();
    set_disp(ALU_OP_EOR, 1'b1, 64'd3, 4'd0, 1'b1, 64'd4, 4'd0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd14);
    step();
    base = iss_cyc.size();
    repeat (3) step();
    chk("stall_no_issue", 64'(iss_cyc.size() - base), 64'd0);
    rs_if.in_flush = 1'b1;
    rs_if.in_alu_ready = 1'b1;
    step();
    repeat (4) step();
    chk("flush_no_issue", 64'(iss_cyc.size() - base), 64'd0);
    chk("flush_dispatch_ready", 64'(rs_if.out_dispatch_ready), 64'd1);

    // Stall then resume.
    rs_if.in_alu_ready = 1'b0;
    set_disp(ALU_OP_EOR, 1'b1, 64'hF0, 4'd0, 1'b1, 64'h0F, 4'd0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd3);
    step();
    repeat (3) step();
    chk("resume_held", 64'(iss_cyc.size() - base), 64'd0);
    push(ALU_OP_EOR, 64'hF0, 64'h0F, 4'd3, 1'b1, 4'd0);
    rs_if.in_alu_ready = 1'b1;
    wait_drain("resume_drain");

    repeat (3) step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, required completion");
    $fatal(1, "watchdog");
  end
endmodule
